// File: rtl/echo_pkg.sv
// Shared widths, saturation limits, FSM encoding and Q2.16 constants for the
// echo cancellation stage.
package echo_pkg;
  localparam int DATA_W    = 16;
  localparam int LAG_W     = 20;
  localparam int COEF_W    = 18;
  localparam int FRAC_BITS = 16;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int TERM_W    = PROD_W - FRAC_BITS;
  localparam int ACC_W     = 36;
  localparam int DIFF_W    = 37;

  localparam logic signed [LAG_W-1:0] RES_MAX = 20'sh7FFFF;
  localparam logic signed [LAG_W-1:0] RES_MIN = 20'sh80000;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic signed [COEF_W-1:0] ONE       = 18'sh10000;
  localparam logic signed [COEF_W-1:0] MINUS_ONE = 18'sh30000;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t c0;
    coef_t c1;
    coef_t c2;
  } coef_set_t;

  // Dropping the low FRAC_BITS of the two's-complement product floors toward -inf.
  function automatic logic signed [TERM_W-1:0] scaled_term(
    input logic signed [DATA_W-1:0] x,
    input coef_t                    c
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(x) * PROD_W'(c);
    return p[PROD_W-1:FRAC_BITS];
  endfunction
endpackage

// File: rtl/echo_tap_delay.sv
// Enabled shift register exposing a LAG+3 sample window (din plus LAG+2 history)
// and the three taps x[n-LAG], x[n-LAG-1], x[n-LAG-2] relative to din = x[n].
module echo_tap_delay
  import echo_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter int LAG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] tap0,
  output logic signed [W-1:0] tap1,
  output logic signed [W-1:0] tap2
);
  localparam int WIN  = LAG + 3;
  localparam int HIST = WIN - 1;

  logic signed [W-1:0] line_q [HIST];
  logic signed [W-1:0] line_d [WIN];

  assign line_d[0] = din;
  generate
    for (genvar gi = 1; gi < WIN; gi++) begin : g_shift
      assign line_d[gi] = line_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '{default: '0};
    end else if (en) begin
      for (int i = 0; i < HIST; i++) line_q[i] <= line_d[i];
    end
  end

  assign tap0 = line_d[LAG];
  assign tap1 = line_d[LAG+1];
  assign tap2 = line_d[LAG+2];
endmodule

// File: rtl/echo_canceller.sv
// 3-tap delayed FIR echo estimate subtracted from signal_lag, saturated to LAG_W.
// Optional macro EC_BYPASS_EN adds a per-sample bypass input.
module echo_canceller
  import echo_pkg::*;
#(
  parameter int LAG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] signal,
  input  logic signed [LAG_W-1:0]  signal_lag,
  input  logic                     coef_load,
  input  logic signed [COEF_W-1:0] para_0,
  input  logic signed [COEF_W-1:0] para_1,
  input  logic signed [COEF_W-1:0] para_2,
`ifdef EC_BYPASS_EN
  input  logic                     bypass,
`endif
  output logic                     out_valid,
  output logic signed [LAG_W-1:0]  echo_free,
  output logic                     sat_flag
);
  localparam int CNT_W = $clog2(LAG + 3);
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(LAG + 2);

  logic                     byp_in;
  logic [0:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  coef_set_t                shadow_q, shadow_d, active_q, active_d, coef_use;
  logic                     pending_q, pending_d, tag_valid;
  logic signed [DATA_W-1:0] tap  [3];
  logic signed [COEF_W-1:0] coef [3];
  logic signed [TERM_W-1:0] term [3];

  logic                     s1_valid_q, s1_byp_q;
  logic signed [TERM_W-1:0] s1_term_q [3];
  logic signed [LAG_W-1:0]  s1_y_q;
  logic                     s2_valid_q, s2_byp_q;
  logic signed [ACC_W-1:0]  s2_acc_q, s2_acc_d;
  logic signed [LAG_W-1:0]  s2_y_q;
  logic signed [DIFF_W-1:0] diff;
  logic                     out_valid_q, sat_q, sat_d;
  logic signed [LAG_W-1:0]  echo_free_q, echo_free_d;

`ifdef EC_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  echo_tap_delay #(.W(DATA_W), .LAG(LAG)) u_taps (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (signal),
    .tap0 (tap[0]),
    .tap1 (tap[1]),
    .tap2 (tap[2])
  );

  // A pending shadow set takes effect on the sample that commits it.
  assign coef_use = pending_q ? shadow_q : active_q;
  assign coef[0]  = coef_use.c0;
  assign coef[1]  = coef_use.c1;
  assign coef[2]  = coef_use.c2;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mul
      assign term[gi] = scaled_term(tap[gi], coef[gi]);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    tag_valid = 1'b0;
    if (in_valid) begin
      active_d  = coef_use;
      pending_d = 1'b0;
      if (state_q == RUN) begin
        tag_valid = 1'b1;
      end else if (cnt_q == LAST_FILL) begin
        tag_valid = 1'b1;
        state_d   = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Applied after the commit so a same-cycle load waits for the next sample.
    if (coef_load) begin
      shadow_d  = '{c0: para_0, c1: para_1, c2: para_2};
      pending_d = 1'b1;
    end
  end

  always_comb begin
    s2_acc_d    = ACC_W'(s1_term_q[0]) + ACC_W'(s1_term_q[1]) + ACC_W'(s1_term_q[2]);
    diff        = DIFF_W'(s2_y_q) - DIFF_W'(s2_acc_q);
    echo_free_d = echo_free_q;
    sat_d       = sat_q;
    if (s2_valid_q) begin
      if (s2_byp_q) begin
        echo_free_d = s2_y_q;
        sat_d       = 1'b0;
      end else if (diff > DIFF_W'(RES_MAX)) begin
        echo_free_d = RES_MAX;
        sat_d       = 1'b1;
      end else if (diff < DIFF_W'(RES_MIN)) begin
        echo_free_d = RES_MIN;
        sat_d       = 1'b1;
      end else begin
        echo_free_d = diff[LAG_W-1:0];
        sat_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_term_q   <= '{default: '0};
      s1_y_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_byp_q    <= 1'b0;
      s2_acc_q    <= '0;
      s2_y_q      <= '0;
      out_valid_q <= 1'b0;
      echo_free_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      s1_valid_q  <= tag_valid;
      s1_byp_q    <= byp_in;
      s1_term_q   <= term;
      s1_y_q      <= signal_lag;
      s2_valid_q  <= s1_valid_q;
      s2_byp_q    <= s1_byp_q;
      s2_acc_q    <= s2_acc_d;
      s2_y_q      <= s1_y_q;
      out_valid_q <= s2_valid_q;
      echo_free_q <= echo_free_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign echo_free = echo_free_q;
  assign sat_flag  = sat_q;
endmodule

// File: tb/tb_echo_canceller.sv
// Self-checking bench: directed test-plan phases with literal expectations,
// then randomized traffic, all checked every cycle against a sample-level model.
module tb_echo_canceller;
  import echo_pkg::*;

  localparam int LAG = 4;
`ifdef EC_BYPASS_EN
  localparam bit BYPASS_BUILT = 1'b1;
`else
  localparam bit BYPASS_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic coef_load = 1'b0;
  logic bypass = 1'b0;
  logic signed [DATA_W-1:0] signal = '0;
  logic signed [LAG_W-1:0]  signal_lag = '0;
  logic signed [COEF_W-1:0] para_0 = '0, para_1 = '0, para_2 = '0;
  logic                     out_valid;
  logic signed [LAG_W-1:0]  echo_free;
  logic                     sat_flag;

  always #5 clk = ~clk;

  echo_canceller #(.LAG(LAG)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .signal     (signal),
    .signal_lag (signal_lag),
    .coef_load  (coef_load),
    .para_0     (para_0),
    .para_1     (para_1),
    .para_2     (para_2),
`ifdef EC_BYPASS_EN
    .bypass     (bypass),
`endif
    .out_valid  (out_valid),
    .echo_free  (echo_free),
    .sat_flag   (sat_flag)
  );

  typedef struct {
    int     due;
    longint res;
    bit     sat;
  } exp_t;

  int     tests = 0;
  int     fails = 0;
  int     edges = 0;
  bit     started = 1'b0;
  exp_t   expq[$];
  longint xs[$];
  longint cur_c[3];
  longint last_res = 0;
  bit     last_sat = 1'b0;
  longint obs[$];
  bit     obs_sat[$];

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Residual for the sample just appended to xs, straight from the definition.
  function automatic exp_t model_result(input int due, input longint y, input bit byp);
    exp_t   r;
    longint acc = 0;
    longint d;
    int     n = xs.size() - 1;
    for (int k = 0; k < 3; k++) acc += (xs[n-LAG-k] * cur_c[k]) >>> FRAC_BITS;
    d = y - acc;
    r.due = due;
    if (byp) begin
      r.res = y; r.sat = 1'b0;
    end else if (d > 524287) begin
      r.res = 524287; r.sat = 1'b1;
    end else if (d < -524288) begin
      r.res = -524288; r.sat = 1'b1;
    end else begin
      r.res = d; r.sat = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    edges++;
    started = 1'b1;
    if (rst) begin
      expq.delete();
      xs.delete();
      cur_c = '{0, 0, 0};
      last_res = 0;
      last_sat = 1'b0;
    end else begin
      if (in_valid) begin
        xs.push_back(longint'(signal));
        if (xs.size() >= LAG + 3)
          expq.push_back(model_result(edges + 2, longint'(signal_lag), bypass && BYPASS_BUILT));
      end
      if (coef_load) cur_c = '{longint'(para_0), longint'(para_1), longint'(para_2)};
    end
  end

  always @(negedge clk) begin : cmp
    bit   exp_v;
    exp_t e;
    if (started) begin
      exp_v = (expq.size() > 0) && (expq[0].due == edges);
      check("out_valid", {63'd0, out_valid}, longint'(exp_v));
      if (exp_v) begin
        e = expq.pop_front();
        check("echo_free", echo_free, e.res);
        check("sat_flag", {63'd0, sat_flag}, longint'(e.sat));
        last_res = e.res;
        last_sat = e.sat;
        obs.push_back(longint'(echo_free));
        obs_sat.push_back(sat_flag);
      end else begin
        check("echo_free_hold", echo_free, last_res);
        check("sat_flag_hold", {63'd0, sat_flag}, longint'(last_sat));
      end
    end
  end

  task automatic send(input longint x, input longint y, input bit load = 1'b0,
                      input longint p0 = 0, input longint p1 = 0, input longint p2 = 0,
                      input bit byp = 1'b0);
    signal = DATA_W'(x);
    signal_lag = LAG_W'(y);
    in_valid = 1'b1;
    coef_load = load;
    bypass = byp;
    if (load) begin
      para_0 = COEF_W'(p0); para_1 = COEF_W'(p1); para_2 = COEF_W'(p2);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_load = 1'b0;
  endtask

  task automatic load(input longint p0, input longint p1, input longint p2);
    para_0 = COEF_W'(p0); para_1 = COEF_W'(p1); para_2 = COEF_W'(p2);
    coef_load = 1'b1;
    @(posedge clk); #1;
    coef_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void clear_obs();
    obs.delete();
    obs_sat.delete();
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(2);
    check("reset_out_valid", {63'd0, out_valid}, 0);
    check("reset_echo_free", echo_free, 0);
    check("reset_sat_flag", {63'd0, sat_flag}, 0);
    rst = 1'b0;

    // Warm-up: zero coefficients pass signal_lag through once sample 6 arrives.
    clear_obs();
    for (int i = 0; i < 10; i++) send(7 * i + 3, 1000);
    idle(4);
    check("warm_count", obs.size(), 4);
    check("warm_first", obs[0], 1000);
    check("warm_first_sat", {63'd0, obs_sat[0]}, 0);

    // Perfect cancel.
    load(ONE, 0, 0);
    clear_obs();
    for (int i = 0; i < 10; i++) send(100, 100);
    idle(4);
    check("cancel_count", obs.size(), 10);
    check("cancel_j4", obs[4], 0);
    check("cancel_j9", obs[9], 0);

    // Positive then negative saturation.
    load(MINUS_ONE, 0, 0);
    clear_obs();
    for (int i = 0; i < 8; i++) send(32767, 524287);
    idle(4);
    check("sat_pos_val", obs[7], 524287);
    check("sat_pos_flag", {63'd0, obs_sat[7]}, 1);
    load(ONE, 0, 0);
    clear_obs();
    for (int i = 0; i < 8; i++) send(32767, -524288);
    idle(4);
    check("sat_neg_val", obs[7], -524288);
    check("sat_neg_flag", {63'd0, obs_sat[7]}, 1);

    // Coefficient load coincident with a sample applies from the next one.
    load(0, 0, 0);
    clear_obs();
    for (int i = 0; i < 8; i++) send(50, 50);
    send(50, 50, 1'b1, ONE, 0, 0);
    send(50, 50);
    idle(4);
    check("coef_bound_count", obs.size(), 10);
    check("coef_bound_same", obs[8], 50);
    check("coef_bound_next", obs[9], 0);

    // Reset with results in flight.
    clear_obs();
    send(1, 11);
    send(2, 22);
    send(3, 33);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 0);
    idle(4);
    check("rst_discard", obs.size(), 1);
    for (int i = 0; i < 7; i++) send($urandom_range(0, 65535), 777);
    idle(4);
    check("rst_restart_count", obs.size(), 2);
    check("rst_restart_val", obs[1], 777);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      coef_load  = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      bypass     = ($urandom_range(0, 4) == 0);
      signal     = DATA_W'($urandom);
      signal_lag = LAG_W'($urandom);
      para_0     = COEF_W'($urandom);
      para_1     = COEF_W'($urandom);
      para_2     = COEF_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; coef_load = 1'b0; rst = 1'b0; bypass = 1'b0;
    idle(4);

`ifdef EC_BYPASS_EN
    load(ONE, 0, 0);
    clear_obs();
    for (int i = 0; i < 8; i++) send(100, 300, 1'b0, 0, 0, 0, 1'b1);
    idle(4);
    check("bypass_on", obs[obs.size()-1], 300);
    check("bypass_on_sat", {63'd0, obs_sat[obs_sat.size()-1]}, 0);
    clear_obs();
    for (int i = 0; i < 4; i++) send(100, 300);
    idle(4);
    check("bypass_off", obs[3], 200);
`endif

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
